// File: rtl/posit_unpack_pipe.sv
// Two-stage posit field extractor: stage 1 captures sign/special flags and the magnitude,
// stage 2 decodes regime, exponent and fraction behind a valid/ready output register.
module posit_unpack_pipe #(
   parameter int WIDTH = 8,
   parameter int ES    = 1,
   localparam int EXP_WIDTH  = $clog2(WIDTH) + ES + 1,
   localparam int FRAC_WIDTH = WIDTH - 3 - ES
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        inValid,
   output logic                        inReady,
   input  logic [WIDTH-1:0]            inPosit,
   output logic                        outValid,
   input  logic                        outReady,
   output logic                        outSign,
   output logic                        outIsZero,
   output logic                        outIsInf,
   output logic signed [EXP_WIDTH-1:0] outExp,
   output logic [FRAC_WIDTH-1:0]       outFrac,
   output logic [15:0]                 infCount
);

   localparam int CNT_WIDTH = $clog2(WIDTH) + 1;

   logic             s1Valid;
   logic             s1Sign;
   logic             s1Zero;
   logic             s1Inf;
   logic [WIDTH-2:0] s1Mag;

   logic s2Load;
   logic s1Load;

   // Handshake: a stage loads when it is empty or its content moves on in the same cycle,
   // so stage 2 is free whenever it holds nothing or the consumer takes it; inReady never
   // looks at inValid.
   assign s2Load  = !outValid || outReady;
   assign s1Load  = !s1Valid || s2Load;
   assign inReady = s1Load;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1Valid <= 1'b0;
         s1Sign  <= 1'b0;
         s1Zero  <= 1'b0;
         s1Inf   <= 1'b0;
         s1Mag   <= '0;
      end else if (s1Load) begin
         s1Valid <= inValid;
         if (inValid) begin
            s1Sign <= inPosit[WIDTH-1];
            s1Zero <= (inPosit == '0);
            s1Inf  <= (inPosit == {1'b1, {(WIDTH-1){1'b0}}});
            // Low bits of a two's-complement negation depend only on the low input bits
            s1Mag  <= inPosit[WIDTH-1] ? -inPosit[WIDTH-2:0] : inPosit[WIDTH-2:0];
         end
      end
   end

   logic                 lead;
   logic                 runOpen;
   logic [CNT_WIDTH-1:0] runLen;
   logic [WIDTH-4:0]     fieldBits;
   logic [EXP_WIDTH-1:0] regimeK;
   logic [EXP_WIDTH-1:0] eBits;
   logic [EXP_WIDTH-1:0] expComb;
   logic [FRAC_WIDTH-1:0] fracComb;

   always_comb begin
      lead    = s1Mag[WIDTH-2];
      runOpen = 1'b1;
      runLen  = '0;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (runOpen && (s1Mag[i] == lead)) begin
            runLen = runLen + CNT_WIDTH'(1);
         end else begin
            runOpen = 1'b0;
         end
      end
      // The run is at least one bit long, so the bits after the terminator start within
      // s1Mag[WIDTH-4:0]; shifting that slice left by runLen-1 MSB-aligns exponent then fraction.
      fieldBits = s1Mag[WIDTH-4:0] << (runLen - CNT_WIDTH'(1));
      regimeK   = lead ? (EXP_WIDTH'(runLen) - EXP_WIDTH'(1)) : -EXP_WIDTH'(runLen);
      eBits     = '0;
      for (int j = 0; j < ES; j++) begin
         eBits = {eBits[EXP_WIDTH-2:0], fieldBits[WIDTH-4-j]};
      end
      expComb  = (regimeK << ES) + eBits;
      fracComb = fieldBits[FRAC_WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         outValid  <= 1'b0;
         outSign   <= 1'b0;
         outIsZero <= 1'b0;
         outIsInf  <= 1'b0;
         outExp    <= '0;
         outFrac   <= '0;
      end else if (s2Load) begin
         outValid <= s1Valid;
         if (s1Valid) begin
            outSign   <= s1Inf | (s1Sign & ~s1Zero);
            outIsZero <= s1Zero;
            outIsInf  <= s1Inf;
            outExp    <= (s1Zero || s1Inf) ? '0 : expComb;
            outFrac   <= (s1Zero || s1Inf) ? '0 : fracComb;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         infCount <= '0;
      end else if (outValid && outReady && outIsInf && (infCount != 16'hFFFF)) begin
         infCount <= infCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// Directed and randomized-ready checks of posit_unpack_pipe (WIDTH=8, ES=1) against
// hand-computed field tables and an independent bit-walking reference decoder.
module tb_posit_unpack_pipe;

   localparam int WIDTH = 8;
   localparam int ES    = 1;
   localparam int REC_W = 12;

   logic              clock = 1'b0;
   logic              reset;
   logic              inValid;
   logic              inReady;
   logic [7:0]        inPosit;
   logic              outValid;
   logic              outReady;
   logic              outSign;
   logic              outIsZero;
   logic              outIsInf;
   logic signed [4:0] outExp;
   logic [3:0]        outFrac;
   logic [15:0]       infCount;

   posit_unpack_pipe #(.WIDTH(WIDTH), .ES(ES)) dut (
      .clock     (clock),
      .reset     (reset),
      .inValid   (inValid),
      .inReady   (inReady),
      .inPosit   (inPosit),
      .outValid  (outValid),
      .outReady  (outReady),
      .outSign   (outSign),
      .outIsZero (outIsZero),
      .outIsInf  (outIsInf),
      .outExp    (outExp),
      .outFrac   (outFrac),
      .infCount  (infCount)
   );

   always #5 clock = ~clock;

   int testsRun    = 0;
   int testsFailed = 0;
   logic [REC_W-1:0] exp_q[$];
   int expInf    = 0;
   int xferCount = 0;
   int narSent   = 0;
   bit readyMode  = 1'b0;
   bit readyLevel = 1'b1;

   logic [7:0]       dirIn[10];
   logic [REC_W-1:0] dirExp[10];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Record layout: {sign, isZero, isInf, exp[4:0], frac[3:0]}
   function automatic logic [REC_W-1:0] rec(input logic s, input logic z, input logic i,
                                             input logic [4:0] e, input logic [3:0] f);
      return {s, z, i, e, f};
   endfunction

   function automatic logic [REC_W-1:0] refDecode(input logic [7:0] w);
      logic [7:0] mag;
      logic       lead;
      logic       e;
      logic [3:0] f;
      int         pos;
      int         runs;
      int         k;
      if (w == 8'h00) return rec(1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
      if (w == 8'h80) return rec(1'b1, 1'b0, 1'b1, 5'd0, 4'd0);
      mag  = w[7] ? (~w + 8'd1) : w;
      lead = mag[6];
      pos  = 6;
      while (pos >= 0 && mag[pos] == lead) pos--;
      runs = 6 - pos;
      k    = lead ? runs - 1 : -runs;
      pos--;
      e = 1'b0;
      if (pos >= 0) begin
         e = mag[pos];
         pos--;
      end
      f = '0;
      for (int b = 3; b >= 0; b--) begin
         if (pos >= 0) begin
            f[b] = mag[pos];
            pos--;
         end
      end
      return rec(w[7], 1'b0, 1'b0, 5'(k * 2 + int'(e)), f);
   endfunction

   // Output scoreboard: a transfer is decided at the next posedge, so sample on the negedge
   always @(negedge clock) begin : monitor
      logic [REC_W-1:0] want;
      if (!reset && outValid && outReady) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            want = exp_q.pop_front();
            check("out_fields", {20'd0, outSign, outIsZero, outIsInf, outExp, outFrac}, {20'd0, want});
            check("inf_count_live", {16'd0, infCount}, expInf);
            if (want[9]) expInf++;
         end
         xferCount++;
      end
   end

   initial begin : readyDriver
      outReady = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         outReady = readyMode ? 1'($urandom_range(0, 1)) : readyLevel;
      end
   end

   task automatic idle(input int n);
      inValid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one word and returns just after the edge that accepted it (inValid left high)
   task automatic sendWord(input logic [7:0] w, input logic [REC_W-1:0] want, output int waited);
      bit ok;
      ok      = 1'b0;
      waited  = 0;
      inValid = 1'b1;
      inPosit = w;
      while (!ok && waited < 200) begin
         @(negedge clock);
         ok = inReady;
         if (ok) exp_q.push_back(want);
         waited++;
         @(posedge clock);
         #1;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      n          = 0;
      readyMode  = 1'b0;
      readyLevel = 1'b1;
      inValid    = 1'b0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic runStream(input int first, input int count);
      int waited;
      int base;
      base = xferCount;
      for (int i = first; i < first + count; i++) begin
         sendWord(dirIn[i], dirExp[i], waited);
         check("no_bubble_accept", waited, 32'd1);
      end
      idle(2);
      check("no_bubble_deliver", xferCount - base, count);
   endtask

   initial begin : mainSeq
      int waited;
      int sel;
      logic [7:0] w;

      dirIn[0] = 8'h40; dirExp[0] = rec(1'b0, 1'b0, 1'b0, 5'd0,  4'b0000);
      dirIn[1] = 8'h4C; dirExp[1] = rec(1'b0, 1'b0, 1'b0, 5'd0,  4'b1100);
      dirIn[2] = 8'h5A; dirExp[2] = rec(1'b0, 1'b0, 1'b0, 5'd1,  4'b1010);
      dirIn[3] = 8'h30; dirExp[3] = rec(1'b0, 1'b0, 1'b0, 5'h1F, 4'b0000);
      dirIn[4] = 8'h00; dirExp[4] = rec(1'b0, 1'b1, 1'b0, 5'd0,  4'b0000);
      dirIn[5] = 8'h80; dirExp[5] = rec(1'b1, 1'b0, 1'b1, 5'd0,  4'b0000);
      dirIn[6] = 8'h01; dirExp[6] = rec(1'b0, 1'b0, 1'b0, 5'h14, 4'b0000);
      dirIn[7] = 8'h7F; dirExp[7] = rec(1'b0, 1'b0, 1'b0, 5'h0C, 4'b0000);
      dirIn[8] = 8'hC0; dirExp[8] = rec(1'b1, 1'b0, 1'b0, 5'd0,  4'b0000);
      dirIn[9] = 8'hB4; dirExp[9] = rec(1'b1, 1'b0, 1'b0, 5'd0,  4'b1100);

      // Clock/reset
      reset   = 1'b1;
      inValid = 1'b0;
      inPosit = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check("rst_outValid", outValid, 32'd0);
      check("rst_infCount", infCount, 32'd0);
      check("rst_fields", {outSign, outIsZero, outIsInf, outExp, outFrac}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_inReady", inReady, 32'd1);
      @(posedge clock);
      #1;

      // Latency on an empty pipe
      sendWord(8'h40, dirExp[0], waited);
      inValid = 1'b0;
      @(negedge clock);
      check("lat_one_cycle", outValid, 32'd0);
      @(posedge clock);
      #1;
      @(negedge clock);
      check("lat_two_cycles", outValid, 32'd1);
      @(posedge clock);
      #1;
      idle(2);

      runStream(0, 4);
      runStream(4, 4);
      check("inf_count_after_nar", infCount, 32'd1);
      runStream(8, 2);

      // Backpressure: two words fill the pipe, third waits
      readyLevel = 1'b0;
      idle(1);
      sendWord(8'h40, dirExp[0], waited);
      check("bp_accept_first", waited, 32'd1);
      sendWord(8'h4C, dirExp[1], waited);
      check("bp_accept_second", waited, 32'd1);
      inPosit = 8'h5A;
      repeat (3) begin
         @(negedge clock);
         check("bp_inReady_low", inReady, 32'd0);
         check("bp_hold_valid", outValid, 32'd1);
         check("bp_hold_frac", outFrac, 32'd0);
         check("bp_hold_exp", {27'd0, outExp}, 32'd0);
         @(posedge clock);
         #1;
      end
      readyLevel = 1'b1;
      sendWord(8'h5A, dirExp[2], waited);
      check("bp_third_accepted", waited, 32'd2);
      drain();
      idle(2);

      // Reset with two words in flight, inValid held during reset
      readyLevel = 1'b0;
      idle(1);
      sendWord(8'h80, dirExp[5], waited);
      sendWord(8'h4C, dirExp[1], waited);
      reset   = 1'b1;
      inValid = 1'b1;
      inPosit = 8'h80;
      exp_q.delete();
      expInf = 0;
      @(posedge clock);
      #1;
      reset      = 1'b0;
      inValid    = 1'b0;
      readyLevel = 1'b1;
      @(negedge clock);
      check("flush_outValid", outValid, 32'd0);
      check("flush_infCount", infCount, 32'd0);
      check("flush_inReady", inReady, 32'd1);
      @(posedge clock);
      #1;
      idle(6);
      check("flush_infCount_later", infCount, 32'd0);

      // Random words and random outReady against the reference decoder
      readyMode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) w = 8'h80;
         else if (sel == 1) w = 8'h00;
         else w = 8'($urandom_range(0, 255));
         if (w == 8'h80) narSent++;
         sendWord(w, refDecode(w), waited);
         if ($urandom_range(0, 5) == 0) idle(1);
      end
      drain();
      idle(2);
      check("inf_count_vs_sent", infCount, narSent);
      check("queue_empty_end", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/posit_unpack_pipe.md
POSIT_UNPACK_PIPE -- requirements
Module: posit_unpack_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the packed posit width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter ES, default 1, meaning the posit exponent-field width (ES <= WIDTH-3).
REQ-003 SHALL define derived localparams EXP_WIDTH = $clog2(WIDTH)+ES+1 (signed combined exponent) and FRAC_WIDTH = WIDTH-3-ES (fraction without hidden bit).
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 inValid  input  1  inPosit holds a word to decode.
REQ-007 inReady  output  1  block accepts inPosit this cycle.
REQ-008 inPosit  input  WIDTH  packed posit word.
REQ-009 outValid  output  1  decoded fields are valid.
REQ-010 outReady  input  1  downstream accepts the decoded fields.
REQ-011 outSign  output  1  sign of the value.
REQ-012 outIsZero  output  1  value is zero.
REQ-013 outIsInf  output  1  value is NaR/infinity.
REQ-014 outExp  output  EXP_WIDTH  signed combined exponent k*2^ES + e.
REQ-015 outFrac  output  FRAC_WIDTH  fraction bits, MSB-aligned, zero-filled.
REQ-016 infCount  output  16  number of NaR words delivered since reset, saturating.

Function
REQ-017 SHALL decode in two register stages; an accepted word SHALL appear on outputs exactly 2 cycles after acceptance when outReady is held high.
REQ-018 Stage 1 SHALL register sign = inPosit[WIDTH-1], isZero = (inPosit == 0), isInf = (inPosit == 1 followed by WIDTH-1 zeros), and the magnitude word (two's complement of inPosit when sign is 1, else inPosit).
REQ-019 Stage 2 SHALL compute regime from magnitude bits [WIDTH-2:0]: run of m leading ones gives k = m-1; run of m leading zeros gives k = -m; a run reaching bit 0 without terminator is legal (k = WIDTH-2 or -(WIDTH-1)+... = -(WIDTH-2) for minpos).
REQ-020 Stage 2 SHALL take the ES bits after the regime terminator as e, with bits shifted off the end treated as zero in the low positions, and the remaining bits as outFrac, MSB-aligned, low bits zero.
REQ-021 When isZero or isInf, outExp and outFrac SHALL be 0 and outSign SHALL be 0 for zero, 1 for NaR.
REQ-022 Stage 2 SHALL load when !outValid || outReady; stage 1 SHALL load when it is empty or stage 2 loads; inReady SHALL equal the stage-1 load condition (combinational, no dependency on inValid).
REQ-023 A word is accepted on a cycle with inValid && inReady; a transfer out occurs on outValid && outReady.
REQ-024 While outValid && !outReady, all out* fields SHALL remain stable; no word SHALL be dropped, duplicated or reordered.
REQ-025 Pipeline bubbles SHALL collapse: an empty stage 2 SHALL accept stage 1 regardless of outReady.
REQ-026 Simultaneous acceptance and delivery SHALL sustain one word per cycle with no bubbles.
REQ-027 infCount SHALL increment by 1 on each output transfer with outIsInf=1 and SHALL hold at 16'hFFFF once reached.

Reset
REQ-028 On reset, both stage valid flags, outValid and infCount SHALL be 0, and out* data fields SHALL be 0, effective the cycle after reset is sampled.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight words; inReady SHALL be 1 in the first cycle after reset deasserts.
REQ-030 inValid during reset SHALL NOT be accepted.

Verification (WIDTH=8, ES=1)
REQ-031 Stream 0x40, 0x4C, 0x5A, 0x30 with outReady=1 -> after 2 cycles, one per cycle: (s0,exp0,frac0000), (s0,exp0,frac1100), (s0,exp1,frac1010), (s0,exp-1,frac0000).
REQ-032 Input 0x00, 0x80, 0x01, 0x7F -> zero(s0); NaR(s1, infCount=1); minpos exp=-12 frac=0; maxpos exp=12 frac=0.
REQ-033 Input 0xC0 and 0xB4 -> (s1,exp0,frac0000) and (s1,exp0,frac1100).
REQ-034 outReady=0, inValid=1 with 0x40,0x4C,0x5A -> two words accepted, inReady=0 thereafter, outputs hold 0x40 decode; raise outReady -> words emerge in order, third accepted, no loss.
REQ-035 Assert reset for 1 cycle with two words in flight -> outValid=0 next cycle, neither word ever delivered, infCount=0.
REQ-036 Random back-to-back stream with random outReady vs. a reference decoder model -> every output matches, order preserved, infCount matches count of 0x80 delivered.
